// File: rtl/aes_seq_pkg.sv
// Shared encodings and constants for the AES-128 / UART command sequencer.
// Frame = opcode byte followed by BLOCK_BYTES payload bytes, first byte lands in the MSB.
package aes_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_KEY,
      S_RX_PT,
      S_START,
      S_WAIT_CORE,
      S_TX_LOAD,
      S_TX_BYTE,
      S_TX_GAP
   } seq_state_e;

   localparam logic [7:0] OP_KEY      = 8'h4B;
   localparam logic [7:0] OP_ENC      = 8'h45;
   localparam logic [7:0] ERR_BYTE    = 8'h3F;
   localparam logic [7:0] ACK_BYTE    = 8'h4B;
   localparam int         BLOCK_BYTES = 16;
   localparam int         BLOCK_W     = 8 * BLOCK_BYTES;

   // Places a single reply byte where the TX shifter emits first.
   function automatic logic [BLOCK_W-1:0] reply_block(input logic [7:0] b);
      return {b, {(BLOCK_W-8){1'b0}}};
   endfunction

endpackage

// File: rtl/aes_seq_shreg.sv
// 128-bit byte shift register: parallel load, shift-in at the LSB byte, shift-out from the MSB byte.
// Load has priority over shift-in, which has priority over shift-out.
module aes_seq_shreg
   import aes_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [BLOCK_W-1:0] load_val_i,
   input  logic               shift_in_i,
   input  logic [7:0]         byte_i,
   input  logic               shift_out_i,
   output logic [BLOCK_W-1:0] q_o
);

   logic [BLOCK_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (shift_in_i) begin
         q_d = {q_q[BLOCK_W-9:0], byte_i};
      end else if (shift_out_i) begin
         q_d = {q_q[BLOCK_W-9:0], 8'h00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/aes_uart_sequencer.sv
// Opcode-frame sequencer between the byte UART and the AES-128 core.
// Define SEQ_TIMEOUT_EN to build the inter-byte RX timeout that aborts stalled frames.
module aes_uart_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 4800000,
   parameter logic [7:0]  OP_KEY         = 8'h4B,
   parameter logic [7:0]  OP_ENC         = 8'h45
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         uart_rx_ready,
   input  logic [7:0]   uart_data_from_rx,
   input  logic         uart_tx_ready,
   output logic [7:0]   uart_data_to_tx,
   output logic         uart_tx_enable,
   output logic [127:0] aes_key,
   output logic [127:0] aes_din,
   output logic         aes_start,
   input  logic         aes_done,
   input  logic [127:0] aes_dout,
   output logic         key_loaded,
   output logic         overrun,
   output logic         frame_err
);

   import aes_seq_pkg::*;

   seq_state_e state_q, state_d;
   logic [3:0] byte_cnt_q, byte_cnt_d;
   logic [4:0] tx_cnt_q, tx_cnt_d;
   logic       key_loaded_q, key_loaded_d;
   logic       overrun_q, overrun_d;
   logic       frame_err_q, frame_err_d;

   logic               key_shift, pt_shift;
   logic               tx_load, tx_shift, tx_en, start;
   logic [BLOCK_W-1:0] tx_load_val;
   logic [BLOCK_W-1:0] key_q, pt_q, tx_q;
   logic [BLOCK_W-9:0] tx_unused;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      tx_cnt_d     = tx_cnt_q;
      key_loaded_d = key_loaded_q;
      overrun_d    = overrun_q;
      frame_err_d  = 1'b0;
      key_shift    = 1'b0;
      pt_shift     = 1'b0;
      tx_load      = 1'b0;
      tx_load_val  = '0;
      tx_shift     = 1'b0;
      tx_en        = 1'b0;
      start        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (uart_rx_ready) begin
               if (uart_data_from_rx == OP_KEY) begin
                  state_d = S_RX_KEY;
               end else if (uart_data_from_rx == OP_ENC) begin
                  state_d = S_RX_PT;
               end else begin
                  tx_load     = 1'b1;
                  tx_load_val = reply_block(ERR_BYTE);
                  tx_cnt_d    = 5'd1;
                  frame_err_d = 1'b1;
                  state_d     = S_TX_BYTE;
               end
            end
         end
         S_RX_KEY: begin
            if (uart_rx_ready) begin
               key_shift  = 1'b1;
               byte_cnt_d = byte_cnt_q + 4'd1;
               if (byte_cnt_q == 4'd15) begin
                  key_loaded_d = 1'b1;
                  tx_load      = 1'b1;
                  tx_load_val  = reply_block(ACK_BYTE);
                  tx_cnt_d     = 5'd1;
                  state_d      = S_TX_BYTE;
               end
            end
         end
         S_RX_PT: begin
            if (uart_rx_ready) begin
               pt_shift   = 1'b1;
               byte_cnt_d = byte_cnt_q + 4'd1;
               if (byte_cnt_q == 4'd15) begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            start   = 1'b1;
            state_d = S_WAIT_CORE;
         end
         S_WAIT_CORE: begin
            if (aes_done) begin
               tx_load     = 1'b1;
               tx_load_val = aes_dout;
               state_d     = S_TX_LOAD;
            end
         end
         S_TX_LOAD: begin
            tx_cnt_d = 5'(BLOCK_BYTES);
            state_d  = S_TX_BYTE;
         end
         S_TX_BYTE: begin
            if (uart_tx_ready) begin
               tx_en    = 1'b1;
               tx_shift = 1'b1;
               tx_cnt_d = tx_cnt_q - 5'd1;
               state_d  = S_TX_GAP;
            end
         end
         S_TX_GAP: begin
            state_d = (tx_cnt_q != 5'd0) ? S_TX_BYTE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Bytes arriving while busy are dropped; the FSM never sees them.
      if (uart_rx_ready && state_q != S_IDLE && state_q != S_RX_KEY && state_q != S_RX_PT) begin
         overrun_d = 1'b1;
      end

`ifdef SEQ_TIMEOUT_EN
      to_cnt_d = '0;
      if (state_q == S_RX_KEY || state_q == S_RX_PT) begin
         if (uart_rx_ready) begin
            to_cnt_d = '0;
         end else if (to_cnt_q == TO_MAX) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = 4'd0;
            state_d     = S_IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         byte_cnt_q   <= '0;
         tx_cnt_q     <= '0;
         key_loaded_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         tx_cnt_q     <= tx_cnt_d;
         key_loaded_q <= key_loaded_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`endif

   aes_seq_shreg u_key (
      .clk        (clk),
      .rst        (rst),
      .load_i     (1'b0),
      .load_val_i ('0),
      .shift_in_i (key_shift),
      .byte_i     (uart_data_from_rx),
      .shift_out_i(1'b0),
      .q_o        (key_q)
   );

   aes_seq_shreg u_pt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (1'b0),
      .load_val_i ('0),
      .shift_in_i (pt_shift),
      .byte_i     (uart_data_from_rx),
      .shift_out_i(1'b0),
      .q_o        (pt_q)
   );

   aes_seq_shreg u_tx (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tx_load),
      .load_val_i (tx_load_val),
      .shift_in_i (1'b0),
      .byte_i     (8'h00),
      .shift_out_i(tx_shift),
      .q_o        (tx_q)
   );

   assign tx_unused       = tx_q[BLOCK_W-9:0];
   assign uart_data_to_tx = tx_en ? tx_q[BLOCK_W-1 -: 8] : 8'h00;
   assign uart_tx_enable  = tx_en;
   assign aes_start       = start;
   assign aes_key         = key_q;
   assign aes_din         = pt_q;
   assign key_loaded      = key_loaded_q;
   assign overrun         = overrun_q;
   assign frame_err       = frame_err_q;

endmodule
